memory_access_arbiter: RTL and testbench
========================================

MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

Interface
REQ-001 SHALL have parameter BITS_DATA, default 32, data word width.
REQ-002 SHALL have parameter BITS_ADDR, default 16, address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0/req1  input  1 each  access request from requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  BITS_ADDR each  access address.
REQ-008 SHALL have ports wdata0/wdata1  input  BITS_DATA each  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1 each  registered grant pulse.
REQ-010 SHALL have ports done0/done1  output  1 each  registered completion pulse.
REQ-011 SHALL have port rdata  output  BITS_DATA  read result, shared by both requesters.
REQ-012 SHALL have port memEn  output  1  memory access strobe.
REQ-013 SHALL have port memWe  output  1  memory write enable.
REQ-014 SHALL have port memAddr  output  BITS_ADDR  memory address.
REQ-015 SHALL have port memWdata  output  BITS_DATA  memory write data.
REQ-016 SHALL have port memRdata  input  BITS_DATA  memory read data, valid the cycle after memEn.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS (any req sampled high), ACCESS->RESP (unconditional) and RESP->IDLE (unconditional).
REQ-019 SHALL sample req0/req1 only in IDLE; requests in ACCESS or RESP are ignored, and a request deasserted mid-transaction does not abort it.
REQ-020 SHALL, on the IDLE->ACCESS edge, latch the winner's we/addr/wdata and assert the winner's gnt for exactly the ACCESS cycle.
REQ-021 SHALL arbitrate round-robin using a lastGrant bit: a sole requester always wins; on simultaneous requests, the requester not granted last wins; lastGrant updates on every grant.
REQ-022 SHALL, during ACCESS only, drive memEn=1, memWe=latched we, and memAddr/memWdata from the latched values; memEn and memWe SHALL be 0 in all other cycles.
REQ-023 SHALL, on the RESP->IDLE edge, load rdata from memRdata for reads and leave rdata unchanged for writes.
REQ-024 SHALL assert the winner's done for exactly one cycle (the IDLE cycle following RESP).
REQ-025 SHALL meet this latency: req sampled at edge N; gnt high in cycle N+1; done high in cycle N+3.
REQ-026 SHALL allow a new grant from the IDLE cycle in which done is high, giving one transaction per 3 cycles.
REQ-027 SHALL sample requester fields at grant time only; the requester must hold them stable until gnt and may change them afterwards.
REQ-028 SHALL treat a requester still holding req in the done cycle as a new transaction.
REQ-029 SHALL never assert gnt0 and gnt1 together, nor done0 and done1 together.

Reset
REQ-030 SHALL, while resetN=0, force state=IDLE, lastGrant=1 and all outputs (gnt, done, rdata, mem*, busy) to 0, asynchronously.
REQ-031 SHALL abort any in-flight transaction on reset, with no done pulse; the first arbitration occurs on the first rising edge with resetN=1.

Verification
REQ-032 Read: req0=1, we0=0, addr0=0x0010, memRdata=0xDEADBEEF -> gnt0 in cycle 1; memEn=1, memAddr=0x0010, memWe=0 in cycle 1; done0 in cycle 3 with rdata=0xDEADBEEF.
REQ-033 Contention: req0 and req1 held high from reset release -> grant order 0,1,0,1 with grants 3 cycles apart and no overlapping gnt or done.
REQ-034 Write: req1=1, we1=1, addr1=0xFFFF, wdata1=0x12345678 -> memWe=1, memWdata=0x12345678, memAddr=0xFFFF in cycle 1; done1 in cycle 3; rdata unchanged.
REQ-035 Reset during ACCESS -> all outputs 0 immediately and no done; after release, with both requesting, req0 wins first.
REQ-036 Sole requester: req1 held high for 9 cycles -> gnt1 in cycles 1, 4 and 7, with no starvation from round-robin.

Source files
------------

// File: rtl/memory_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Each transaction takes three cycles: grant/access, response wait, completion.
module memory_access_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata0,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [BITS_DATA-1:0] rdata,
    output logic                 memEn,
    output logic                 memWe,
    output logic [BITS_ADDR-1:0] memAddr,
    output logic [BITS_DATA-1:0] memWdata,
    input  logic [BITS_DATA-1:0] memRdata,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   grant;
    logic                   pick;
    logic                   last_grant;
    logic                   owner;
    logic                   lat_we;
    logic [BITS_ADDR-1:0]   lat_addr;
    logic [BITS_DATA-1:0]   lat_wdata;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        pick       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    // Contention goes to whoever was not served last; a sole requester always wins.
                    pick       = (req0 && req1) ? ~last_grant : req1;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_next;
            gnt0  <= grant && !pick;
            gnt1  <= grant && pick;
            done0 <= (state == RESP) && !owner;
            done1 <= (state == RESP) && owner;
            if (grant) begin
                owner      <= pick;
                last_grant <= pick;
                lat_we     <= pick ? we1    : we0;
                lat_addr   <= pick ? addr1  : addr0;
                lat_wdata  <= pick ? wdata1 : wdata0;
            end
            // Read data arrives in the cycle after the access strobe, i.e. during RESP.
            if ((state == RESP) && !lat_we) begin
                rdata <= memRdata;
            end
        end
    end

    assign memEn    = (state == ACCESS);
    assign memWe    = (state == ACCESS) && lat_we;
    assign memAddr  = (state == ACCESS) ? lat_addr  : '0;
    assign memWdata = (state == ACCESS) ? lat_wdata : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Self-checking bench for memory_access_arbiter: directed scenarios plus random
// traffic compared against a transaction-timeline reference model.
module tb_memory_access_arbiter;

    localparam int BD = 32;
    localparam int BA = 16;

    logic          clk = 1'b0;
    logic          resetN;
    logic          req0, req1, we0, we1;
    logic [BA-1:0] addr0, addr1;
    logic [BD-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [BD-1:0] rdata;
    logic          memEn, memWe;
    logic [BA-1:0] memAddr;
    logic [BD-1:0] memWdata;
    logic [BD-1:0] memRdata;
    logic          busy;

    memory_access_arbiter #(.BITS_DATA(BD), .BITS_ADDR(BA)) dut (
        .clk(clk), .resetN(resetN),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .memEn(memEn), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one transaction record positioned on an absolute edge timeline.
    int            edge_n = 0;
    int            g_edge;
    bit            lg, t_who, t_we;
    logic [BA-1:0] t_addr;
    logic [BD-1:0] t_wdata, exp_rdata;
    logic          e_gnt0, e_gnt1, e_done0, e_done1, e_en, e_we, e_busy;
    logic [BA-1:0] e_addr;
    logic [BD-1:0] e_wdata;

    task automatic model_reset();
        g_edge    = -100;
        lg        = 1'b1;
        exp_rdata = '0;
    endtask

    // Advance one rising edge, update the model from the inputs seen there, return 1ns later.
    task automatic step();
        int e, d;
        @(posedge clk);
        e = edge_n;
        edge_n++;
        if (!resetN) begin
            model_reset();
        end else begin
            if (g_edge >= 0 && e == g_edge + 2 && !t_we) exp_rdata = memRdata;
            if (e >= g_edge + 3 && (req0 || req1)) begin
                t_who   = (req0 && req1) ? !lg : req1;
                lg      = t_who;
                g_edge  = e;
                t_we    = t_who ? we1 : we0;
                t_addr  = t_who ? addr1 : addr0;
                t_wdata = t_who ? wdata1 : wdata0;
            end
        end
        d       = e + 1 - g_edge;
        e_gnt0  = (d == 1) && !t_who;
        e_gnt1  = (d == 1) && t_who;
        e_done0 = (d == 3) && !t_who;
        e_done1 = (d == 3) && t_who;
        e_en    = (d == 1);
        e_we    = (d == 1) && t_we;
        e_busy  = (d == 1) || (d == 2);
        e_addr  = (d == 1) ? t_addr : '0;
        e_wdata = (d == 1) ? t_wdata : '0;
        #1;
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        resetN   = 1'b0;
        memRdata = '0;
        drive_idle();
        model_reset();
        #2;
        total++;
        if ({gnt0, gnt1, done0, done1, memEn, memWe, busy} !== 7'b0 || rdata !== '0 ||
            memAddr !== '0 || memWdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ctrl=%b rdata=%h addr=%h wdata=%h, want all zero",
                     {gnt0, gnt1, done0, done1, memEn, memWe, busy}, rdata, memAddr, memWdata);
        end
        req0 = 1; req1 = 1;
        step();
        step();
        total++;
        if ({gnt0, gnt1, busy} !== 3'b0) begin
            bad++;
            $display("FAIL reset_held: gnt0/gnt1/busy=%b want 000", {gnt0, gnt1, busy});
        end
        drive_idle();
        resetN = 1'b1;
        step();
    endtask

    task automatic test_read();
        req0 = 1; we0 = 0; addr0 = 16'h0010; memRdata = 32'hDEADBEEF;
        step();
        total++;
        if ({gnt0, gnt1, memEn, memWe} !== 4'b1010 || memAddr !== 16'h0010) begin
            bad++;
            $display("FAIL read_access: gnt0/gnt1/memEn/memWe=%b addr=%h want 1010 addr=0010",
                     {gnt0, gnt1, memEn, memWe}, memAddr);
        end
        req0 = 0; addr0 = 16'h5555;
        step();
        step();
        total++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_done: done0=%b done1=%b rdata=%h want 1 0 deadbeef",
                     done0, done1, rdata);
        end
        step();
    endtask

    task automatic test_write();
        req1 = 1; we1 = 1; addr1 = 16'hFFFF; wdata1 = 32'h12345678; memRdata = 32'hA5A5A5A5;
        step();
        total++;
        if ({gnt1, memEn, memWe} !== 3'b111 || memAddr !== 16'hFFFF || memWdata !== 32'h12345678) begin
            bad++;
            $display("FAIL write_access: gnt1/memEn/memWe=%b addr=%h wdata=%h want 111 ffff 12345678",
                     {gnt1, memEn, memWe}, memAddr, memWdata);
        end
        req1 = 0; we1 = 0; wdata1 = '0;
        step();
        step();
        total++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_done: done1=%b done0=%b rdata=%h want 1 0 deadbeef",
                     done1, done0, rdata);
        end
        step();
    endtask

    task automatic test_contention();
        resetN = 1'b0;
        req0 = 1; req1 = 1;
        #2;
        step();
        resetN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] want;
            step();
            want = {k % 6 == 1, k % 6 == 4, k % 6 == 3, k % 6 == 0};
            if (k == 12) begin
                req0 = 0; req1 = 0;
            end
            total++;
            if ({gnt0, gnt1, done0, done1} !== want) begin
                bad++;
                $display("FAIL contention k=%0d: gnt0/gnt1/done0/done1=%b want %b",
                         k, {gnt0, gnt1, done0, done1}, want);
            end
        end
        step();
    endtask

    task automatic test_sole();
        req1 = 1; we1 = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 9) req1 = 0;
            total++;
            if (gnt1 !== (k % 3 == 1) || gnt0 !== 1'b0) begin
                bad++;
                $display("FAIL sole k=%0d: gnt1=%b gnt0=%b want %b 0", k, gnt1, gnt0, k % 3 == 1);
            end
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 1; addr0 = 16'h1234; wdata0 = 32'hCAFEF00D;
        step();
        total++;
        if (gnt0 !== 1'b1 || memEn !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: gnt0=%b memEn=%b want 1 1", gnt0, memEn);
        end
        #2 resetN = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, done0, done1, memEn, memWe, busy} !== 7'b0 || memAddr !== '0 ||
            memWdata !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: ctrl=%b addr=%h wdata=%h rdata=%h want zero",
                     {gnt0, gnt1, done0, done1, memEn, memWe, busy}, memAddr, memWdata, rdata);
        end
        req1 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({done0, done1, gnt0, gnt1} !== 4'b0) begin
                bad++;
                $display("FAIL reset_mid_held k=%0d: done/gnt=%b want 0000", k, {done0, done1, gnt0, gnt1});
            end
        end
        resetN = 1'b1;
        step();
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_first: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        drive_idle();
        step();
        step();
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req0     = ($urandom_range(0, 3) != 0);
            req1     = ($urandom_range(0, 2) != 0);
            we0      = $urandom_range(0, 1);
            we1      = $urandom_range(0, 1);
            addr0    = BA'($urandom);
            addr1    = BA'($urandom);
            wdata0   = $urandom;
            wdata1   = $urandom;
            memRdata = $urandom;
            step();
            total++;
            if ({gnt0, gnt1, done0, done1, memEn, memWe, busy} !==
                {e_gnt0, e_gnt1, e_done0, e_done1, e_en, e_we, e_busy}) begin
                bad++;
                $display("FAIL random_ctrl k=%0d: gnt0 gnt1 done0 done1 en we busy=%b want %b", k,
                         {gnt0, gnt1, done0, done1, memEn, memWe, busy},
                         {e_gnt0, e_gnt1, e_done0, e_done1, e_en, e_we, e_busy});
            end
            total++;
            if (memAddr !== e_addr || memWdata !== e_wdata) begin
                bad++;
                $display("FAIL random_mem k=%0d: addr=%h wdata=%h want %h %h",
                         k, memAddr, memWdata, e_addr, e_wdata);
            end
            total++;
            if (rdata !== exp_rdata) begin
                bad++;
                $display("FAIL random_rdata k=%0d: rdata=%h want %h", k, rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_sole();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
